// File: rtl/pbs_pkg.sv
// Shared definitions for the battle datapath slice.
// Holds the datapath state encoding, default widths/limits, and the
// damage shift applied to the raw power*attack product.
package pbs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_APPLY,
    ST_DONE
  } dp_state_t;

  localparam int unsigned HP_W_DEF   = 8;
  localparam int unsigned MAX_HP_DEF = 100;
  localparam int unsigned PWR_W_DEF  = 6;
  localparam int unsigned ATK_W_DEF  = 4;

  // Damage = product >> DMG_SHIFT
  localparam int unsigned DMG_SHIFT  = 2;

endpackage

// File: rtl/battle_datapath_if.sv
// Command/status bundle between the battle control FSM (master) and the
// battle datapath (slave).
//   commands : load_ai_hp, ai_hp_init, apply_ai_damage, apply_p_damage,
//              active_trainer, target, p_power, ai_power, p_atk, ai_atk
//   status   : p_hp, ai_hp, p_fainted, ai_fainted, busy, done, err
interface battle_datapath_if
  import pbs_pkg::*;
#(
  parameter int unsigned HP_W  = HP_W_DEF,
  parameter int unsigned PWR_W = PWR_W_DEF,
  parameter int unsigned ATK_W = ATK_W_DEF
);
  logic             load_ai_hp;
  logic [HP_W-1:0]  ai_hp_init;
  logic             apply_ai_damage;
  logic             apply_p_damage;
  logic             active_trainer;
  logic             target;
  logic [PWR_W-1:0] p_power;
  logic [PWR_W-1:0] ai_power;
  logic [ATK_W-1:0] p_atk;
  logic [ATK_W-1:0] ai_atk;

  logic [HP_W-1:0]  p_hp;
  logic [HP_W-1:0]  ai_hp;
  logic             p_fainted;
  logic             ai_fainted;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output load_ai_hp, ai_hp_init, apply_ai_damage, apply_p_damage,
           active_trainer, target, p_power, ai_power, p_atk, ai_atk,
    input  p_hp, ai_hp, p_fainted, ai_fainted, busy, done, err
  );

  modport slave (
    input  load_ai_hp, ai_hp_init, apply_ai_damage, apply_p_damage,
           active_trainer, target, p_power, ai_power, p_atk, ai_atk,
    output p_hp, ai_hp, p_fainted, ai_fainted, busy, done, err
  );
endinterface

// File: rtl/battle_datapath_mul.sv
// shift_add_mul: unsigned shift-add multiplier taking exactly B_W cycles.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   i_start     : load operands (ignored while running)
//   i_a, i_b    : multiplicand / multiplier
//   o_last      : high during the final step; o_product is valid from the
//                 following edge until the next start
//   o_product   : A_W+B_W bit result
module shift_add_mul #(
  parameter int unsigned A_W = 6,
  parameter int unsigned B_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic [A_W-1:0]     i_a,
  input  logic [B_W-1:0]     i_b,
  output logic               o_last,
  output logic [A_W+B_W-1:0] o_product
);
  localparam int unsigned P_W = A_W + B_W;
  localparam int unsigned CW  = (B_W > 1) ? $clog2(B_W) : 1;

  logic           r_busy;
  logic [CW-1:0]  r_cnt;
  logic [P_W-1:0] r_mcand;
  logic [B_W-1:0] r_mplier;
  logic [P_W-1:0] r_acc;

  assign o_last    = r_busy && (r_cnt == CW'(B_W - 1));
  assign o_product = r_acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (i_start && !r_busy) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_mcand  <= P_W'(i_a);
      r_mplier <= i_b;
      r_acc    <= '0;
    end else if (r_busy) begin
      if (r_mplier[0]) begin
        r_acc <= r_acc + r_mcand;
      end
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (o_last) begin
        r_busy <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/battle_datapath.sv
// battle_datapath: owns both HP registers and executes the battle FSM's
// level commands on their rising edges.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : battle_datapath_if slave (commands in, HP/fainted/busy/
//                done/err out)
// Flow: IDLE -(valid apply edge)-> MUL (ATK_W cycles) -> APPLY -> DONE.
// A load edge is executed directly from IDLE. Rejected commands pulse err
// one cycle later with no state change.
module battle_datapath
  import pbs_pkg::*;
#(
  parameter int unsigned HP_W   = HP_W_DEF,
  parameter int unsigned MAX_HP = MAX_HP_DEF,
  parameter int unsigned PWR_W  = PWR_W_DEF,
  parameter int unsigned ATK_W  = ATK_W_DEF
) (
  input logic              clk,
  input logic              reset,
  battle_datapath_if.slave bus
);
  localparam int unsigned PROD_W = PWR_W + ATK_W;
  localparam int unsigned XW     = (PROD_W > HP_W) ? PROD_W : HP_W;
  localparam logic [HP_W-1:0] HP_MAX_L = HP_W'(MAX_HP);

  dp_state_t r_state, w_state_d;

  logic r_load_q, r_aid_q, r_pd_q;
  logic w_load_e, w_aid_e, w_pd_e, w_any_e;
  logic w_qual_ok;

  logic w_start, w_load_do, w_apply, w_err;
  logic r_err, r_tgt;

  logic [PWR_W-1:0]  w_mul_a;
  logic [ATK_W-1:0]  w_mul_b;
  logic              w_mul_last;
  logic [PROD_W-1:0] w_prod;

  logic [XW-1:0]   w_prod_x;
  logic [XW-1:0]   w_sat_lim;
  logic [HP_W-1:0] w_dmg, w_cur_hp, w_new_hp, w_load_val;
  logic [HP_W-1:0] r_p_hp, r_ai_hp;

  // Edge detection runs every cycle, so edges seen while busy are consumed.
  assign w_load_e = bus.load_ai_hp      & ~r_load_q;
  assign w_aid_e  = bus.apply_ai_damage & ~r_aid_q;
  assign w_pd_e   = bus.apply_p_damage  & ~r_pd_q;
  assign w_any_e  = w_load_e | w_aid_e | w_pd_e;

  assign w_qual_ok = w_aid_e ? (~bus.active_trainer &  bus.target)
                             : ( bus.active_trainer & ~bus.target);

  assign w_mul_a = bus.active_trainer ? bus.ai_power : bus.p_power;
  assign w_mul_b = bus.active_trainer ? bus.ai_atk   : bus.p_atk;

  shift_add_mul #(
    .A_W(PWR_W),
    .B_W(ATK_W)
  ) u_mul (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_start),
    .i_a       (w_mul_a),
    .i_b       (w_mul_b),
    .o_last    (w_mul_last),
    .o_product (w_prod)
  );

  // Damage saturates at all-ones of HP_W, then saturating subtract.
  assign w_prod_x   = XW'(w_prod) >> DMG_SHIFT;
  assign w_sat_lim  = XW'({HP_W{1'b1}});
  assign w_dmg      = (w_prod_x > w_sat_lim) ? '1 : w_prod_x[HP_W-1:0];
  assign w_cur_hp   = r_tgt ? r_ai_hp : r_p_hp;
  assign w_new_hp   = (w_cur_hp > w_dmg) ? (w_cur_hp - w_dmg) : '0;
  assign w_load_val = (bus.ai_hp_init > HP_MAX_L) ? HP_MAX_L : bus.ai_hp_init;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_load_q <= 1'b0;
      r_aid_q  <= 1'b0;
      r_pd_q   <= 1'b0;
      r_err    <= 1'b0;
      r_tgt    <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_load_q <= bus.load_ai_hp;
      r_aid_q  <= bus.apply_ai_damage;
      r_pd_q   <= bus.apply_p_damage;
      r_err    <= w_err;
      if (w_start) begin
        r_tgt <= bus.target;
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_start   = 1'b0;
    w_load_do = 1'b0;
    w_apply   = 1'b0;
    w_err     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_load_e) begin
          // Load wins; a simultaneous apply is dropped and flagged.
          w_load_do = 1'b1;
          w_err     = w_aid_e | w_pd_e;
        end else if (w_aid_e && w_pd_e) begin
          w_err = 1'b1;
        end else if (w_aid_e || w_pd_e) begin
          if (w_qual_ok) begin
            w_start   = 1'b1;
            w_state_d = ST_MUL;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      ST_MUL: begin
        w_err = w_any_e;
        if (w_mul_last) begin
          w_state_d = ST_APPLY;
        end
      end
      ST_APPLY: begin
        w_err     = w_any_e;
        w_apply   = 1'b1;
        w_state_d = ST_DONE;
      end
      ST_DONE: begin
        w_err     = w_any_e;
        w_state_d = ST_IDLE;
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_p_hp  <= HP_MAX_L;
      r_ai_hp <= HP_MAX_L;
    end else begin
      if (w_load_do) begin
        r_ai_hp <= w_load_val;
      end
      if (w_apply) begin
        if (r_tgt) begin
          r_ai_hp <= w_new_hp;
        end else begin
          r_p_hp <= w_new_hp;
        end
      end
    end
  end

  assign bus.p_hp       = r_p_hp;
  assign bus.ai_hp      = r_ai_hp;
  assign bus.p_fainted  = (r_p_hp == '0);
  assign bus.ai_fainted = (r_ai_hp == '0);
  assign bus.busy       = (r_state == ST_MUL) || (r_state == ST_APPLY);
  assign bus.done       = (r_state == ST_DONE);
  assign bus.err        = r_err;
endmodule
